reg32_seq: RTL and testbench

REG32_SEQ -- requirements
Module: reg32_seq

---
 rtl/reg32_seq_if.sv | 31 +++
 rtl/reg32_seq.sv | 129 ++++++++++++
 tb/tb_reg32_seq.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg32_seq_if.sv
// Bundles the job-request inputs and the shift-register control outputs of reg32_seq.
// START is taken only while BUSY=0; BIT_OUT is meaningful only when BIT_VLD=1; DONE pulses one cycle.
interface reg32_seq_if;
   logic        START;
   logic        ABORT;
   logic [31:0] WORD;
   logic [4:0]  LEN;
   logic        ROT;
   logic        DIR_IN;
   logic        FILL;
   logic        S_OUT;
   logic        ENB;
   logic        DIR;
   logic        S_IN;
   logic [1:0]  MODO;
   logic [31:0] D;
   logic        BUSY;
   logic        DONE;
   logic        BIT_OUT;
   logic        BIT_VLD;

   modport slave (
      input  START, ABORT, WORD, LEN, ROT, DIR_IN, FILL, S_OUT,
      output ENB, DIR, S_IN, MODO, D, BUSY, DONE, BIT_OUT, BIT_VLD
   );

   modport master (
      output START, ABORT, WORD, LEN, ROT, DIR_IN, FILL, S_OUT,
      input  ENB, DIR, S_IN, MODO, D, BUSY, DONE, BIT_OUT, BIT_VLD
   );
endinterface

// File: rtl/reg32_seq.sv
// Load-and-shift sequencer driving an external 32-bit shift register.
// Moore FSM IDLE -> LOAD -> SHIFT (N cycles) -> FIN; every output comes straight from a flop.
module reg32_seq (
   input  logic       CLK,
   input  logic       RESET_L,
   reg32_seq_if.slave bus,
   output logic [1:0] stateDbg
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      FIN   = 2'd3
   } stateT;

   stateT       stateQ;
   stateT       stateNxt;
   logic [31:0] wordQ;
   logic [4:0]  cntQ;
   logic        rotQ;
   logic        dirQ;
   logic        fillQ;
   logic        enbQ;
   logic        busyQ;
   logic        doneQ;
   logic [1:0]  modoQ;
   logic        bitOutQ;
   logic        bitVldQ;
   logic        enbNxt;
   logic        busyNxt;
   logic        doneNxt;
   logic [1:0]  modoNxt;
   logic        accept;
   logic        shiftEdge;

   assign accept    = (stateQ == IDLE) && bus.START;
   // An aborted SHIFT edge is not a shift edge: nothing is captured from it.
   assign shiftEdge = (stateQ == SHIFT) && !bus.ABORT;

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         stateQ <= IDLE;
         enbQ   <= 1'b0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
         modoQ  <= 2'b00;
      end else begin
         stateQ <= stateNxt;
         enbQ   <= enbNxt;
         busyQ  <= busyNxt;
         doneQ  <= doneNxt;
         modoQ  <= modoNxt;
      end
   end

   always_comb begin
      stateNxt = stateQ;
      case (stateQ)
         IDLE:    if (bus.START) stateNxt = LOAD;
         LOAD:    stateNxt = bus.ABORT ? IDLE : SHIFT;
         SHIFT: begin
            if (bus.ABORT)       stateNxt = IDLE;
            else if (cntQ == 5'd0) stateNxt = FIN;
         end
         FIN:     stateNxt = IDLE;
         default: stateNxt = IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so they land in flops together with it.
   always_comb begin
      enbNxt  = 1'b0;
      busyNxt = 1'b0;
      doneNxt = 1'b0;
      modoNxt = 2'b00;
      case (stateNxt)
         LOAD: begin
            enbNxt  = 1'b1;
            busyNxt = 1'b1;
            modoNxt = 2'b10;
         end
         SHIFT: begin
            enbNxt  = 1'b1;
            busyNxt = 1'b1;
            modoNxt = {1'b0, rotQ};
         end
         FIN: begin
            busyNxt = 1'b1;
            doneNxt = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         wordQ   <= '0;
         cntQ    <= '0;
         rotQ    <= 1'b0;
         dirQ    <= 1'b0;
         fillQ   <= 1'b0;
         bitOutQ <= 1'b0;
         bitVldQ <= 1'b0;
      end else begin
         if (accept) begin
            wordQ <= bus.WORD;
            cntQ  <= bus.LEN;
            rotQ  <= bus.ROT;
            dirQ  <= bus.DIR_IN;
            fillQ <= bus.FILL;
         end else if (shiftEdge && (cntQ != 5'd0)) begin
            cntQ <= cntQ - 5'd1;
         end
         bitVldQ <= shiftEdge;
         if (shiftEdge) bitOutQ <= bus.S_OUT;
      end
   end

   assign bus.ENB     = enbQ;
   assign bus.DIR     = dirQ;
   assign bus.S_IN    = fillQ;
   assign bus.MODO    = modoQ;
   assign bus.D       = wordQ;
   assign bus.BUSY    = busyQ;
   assign bus.DONE    = doneQ;
   assign bus.BIT_OUT = bitOutQ;
   assign bus.BIT_VLD = bitVldQ;
   assign stateDbg    = stateQ;
endmodule

// File: tb/tb_reg32_seq.sv
// Bench for reg32_seq: behavioural shift register on the bus, expected-value queues,
// a negedge monitor that pops and compares, and randomized plus directed jobs.
module tb_reg32_seq;
   logic       CLK = 1'b0;
   logic       RESET_L;
   logic [1:0] stateDbg;
   int         checks = 0;
   int         errors = 0;
   logic [31:0] srModel = '0;

   logic [31:0] expLoadQ[$];
   logic [3:0]  expShiftQ[$];
   logic [0:0]  expBitQ[$];
   logic [31:0] expDoneQ[$];

   reg32_seq_if bus ();

   reg32_seq dut (
      .CLK      (CLK),
      .RESET_L  (RESET_L),
      .bus      (bus.slave),
      .stateDbg (stateDbg)
   );

   always #5 CLK = ~CLK;

   // External shift register: DIR=0 shifts toward bit 0, DIR=1 toward bit 31.
   always @(posedge CLK) begin
      if (bus.ENB) begin
         case (bus.MODO)
            2'b10:   srModel <= bus.D;
            2'b00:   srModel <= bus.DIR ? {srModel[30:0], bus.S_IN} : {bus.S_IN, srModel[31:1]};
            2'b01:   srModel <= bus.DIR ? {srModel[30:0], srModel[31]} : {srModel[0], srModel[31:1]};
            default: srModel <= srModel;
         endcase
      end
   end
   assign bus.S_OUT = bus.DIR ? srModel[31] : srModel[0];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
   endtask

   function automatic logic [31:0] finalWord(input logic [31:0] w, input int n,
                                             input logic rot, input logic dir, input logic fill);
      logic [63:0] t;
      if (rot && !dir) begin
         t = {w, w} >> n;
         return t[31:0];
      end else if (rot) begin
         t = {w, w} << n;
         return t[63:32];
      end else if (!dir) begin
         t = {{32{fill}}, w} >> n;
         return t[31:0];
      end else begin
         t = {w, {32{fill}}} << n;
         return t[63:32];
      end
   endfunction

   task automatic pushJob(input logic [31:0] w, input logic [4:0] len, input logic rot,
                          input logic dir, input logic fill, input int shiftSeen,
                          input int bitsSeen, input logic doneExp);
      expLoadQ.push_back(w);
      for (int i = 0; i < shiftSeen; i++) expShiftQ.push_back({dir, 1'b0, rot, fill});
      for (int i = 0; i < bitsSeen; i++) expBitQ.push_back(dir ? w[31-i] : w[i]);
      if (doneExp) expDoneQ.push_back(finalWord(w, int'(len) + 1, rot, dir, fill));
   endtask

   task automatic scramble();
      bus.WORD   = $urandom;
      bus.LEN    = 5'($urandom_range(0, 31));
      bus.ROT    = 1'($urandom_range(0, 1));
      bus.DIR_IN = 1'($urandom_range(0, 1));
      bus.FILL   = 1'($urandom_range(0, 1));
   endtask

   task automatic waitIdle();
      for (int i = 0; i < 200; i++) begin
         if (bus.BUSY === 1'b0) return;
         @(negedge CLK);
         #1;
      end
      checks++;
      errors++;
      $display("FAIL waitIdle: BUSY still %b after 200 cycles", bus.BUSY);
   endtask

   task automatic checkResetValues(input string tag);
      check({tag, " ENB"}, bus.ENB, 0);
      check({tag, " DIR"}, bus.DIR, 0);
      check({tag, " S_IN"}, bus.S_IN, 0);
      check({tag, " MODO"}, bus.MODO, 0);
      check({tag, " D"}, bus.D, 0);
      check({tag, " BUSY"}, bus.BUSY, 0);
      check({tag, " DONE"}, bus.DONE, 0);
      check({tag, " BIT_OUT"}, bus.BIT_OUT, 0);
      check({tag, " BIT_VLD"}, bus.BIT_VLD, 0);
      check({tag, " state"}, stateDbg, 0);
   endtask

   // abortAt: -1 none, 0 abort in LOAD, j abort in the j-th SHIFT cycle.
   task automatic runJob(input logic [31:0] w, input logic [4:0] len, input logic rot,
                         input logic dir, input logic fill, input int abortAt,
                         input logic abortWithStart);
      int n;
      n = int'(len) + 1;
      waitIdle();
      bus.WORD   = w;
      bus.LEN    = len;
      bus.ROT    = rot;
      bus.DIR_IN = dir;
      bus.FILL   = fill;
      bus.START  = 1'b1;
      bus.ABORT  = abortWithStart;
      if (abortAt < 0) pushJob(w, len, rot, dir, fill, n, n, 1'b1);
      else pushJob(w, len, rot, dir, fill, abortAt, (abortAt > 0) ? abortAt - 1 : 0, 1'b0);
      @(negedge CLK);
      #1;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      scramble();
      if (abortAt >= 0) begin
         for (int i = 0; i < abortAt; i++) begin
            @(negedge CLK);
            #1;
         end
         bus.ABORT = 1'b1;
         @(negedge CLK);
         #1;
         bus.ABORT = 1'b0;
         check("abort ENB", bus.ENB, 0);
         check("abort BUSY", bus.BUSY, 0);
         check("abort DONE", bus.DONE, 0);
         check("abort BIT_VLD", bus.BIT_VLD, 0);
      end
   endtask

   always @(negedge CLK) begin
      if (RESET_L === 1'b1) begin
         if (bus.ENB && bus.MODO == 2'b10) begin
            if (expLoadQ.size() == 0) unexpected("load");
            else check("load D", bus.D, expLoadQ.pop_front());
         end else if (bus.ENB) begin
            if (expShiftQ.size() == 0) unexpected("shift");
            else check("shift DIR/MODO/S_IN", {28'b0, bus.DIR, bus.MODO, bus.S_IN},
                       {28'b0, expShiftQ.pop_front()});
         end else begin
            check("idle MODO", bus.MODO, 0);
         end
         if (bus.BIT_VLD) begin
            if (expBitQ.size() == 0) unexpected("bit");
            else check("BIT_OUT", bus.BIT_OUT, expBitQ.pop_front());
         end
         if (bus.DONE) begin
            if (expDoneQ.size() == 0) unexpected("done");
            else check("register at DONE", srModel, expDoneQ.pop_front());
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] curWord;
      logic [1:0]  combo;
      int          len;
      int          abortAt;

      RESET_L   = 1'b0;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      scramble();
      repeat (2) @(negedge CLK);
      #1;
      checkResetValues("reset");
      RESET_L = 1'b1;

      // Basic shift job with per-cycle BUSY/DONE timing.
      waitIdle();
      bus.WORD   = 32'hA5A5_0001;
      bus.LEN    = 5'd3;
      bus.ROT    = 1'b0;
      bus.DIR_IN = 1'b0;
      bus.FILL   = 1'($urandom_range(0, 1));
      bus.START  = 1'b1;
      pushJob(32'hA5A5_0001, 5'd3, 1'b0, 1'b0, bus.FILL, 4, 4, 1'b1);
      for (int c = 1; c <= 7; c++) begin
         @(negedge CLK);
         #1;
         if (c == 1) begin
            bus.START = 1'b0;
            scramble();
         end
         check("basic BUSY", bus.BUSY, 32'(c <= 6));
         check("basic DONE", bus.DONE, 32'(c == 6));
      end

      // Full 32-step rotate returns the word.
      runJob(32'h8000_0001, 5'd31, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, 1'b0);

      // Abort in the third SHIFT cycle.
      runJob($urandom, 5'd7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 3, 1'b0);

      // START held high with LEN=0: jobs every 4 cycles, D fixed within a job.
      waitIdle();
      curWord = '0;
      for (int j = 0; j < 12; j++) begin
         bus.WORD   = $urandom;
         bus.LEN    = 5'd0;
         bus.ROT    = 1'($urandom_range(0, 1));
         bus.DIR_IN = 1'($urandom_range(0, 1));
         bus.FILL   = 1'($urandom_range(0, 1));
         bus.START  = 1'b1;
         if (j % 4 == 0) begin
            curWord = bus.WORD;
            pushJob(bus.WORD, 5'd0, bus.ROT, bus.DIR_IN, bus.FILL, 1, 1, 1'b1);
         end
         @(negedge CLK);
         #1;
         check("repeat BUSY", bus.BUSY, 32'(((j + 1) % 4) != 0));
         if (((j + 1) % 4) != 0) check("repeat D hold", bus.D, curWord);
      end
      bus.START = 1'b0;

      // Asynchronous reset in the middle of SHIFT, then an immediate restart.
      waitIdle();
      bus.WORD   = $urandom;
      bus.LEN    = 5'd7;
      bus.ROT    = 1'($urandom_range(0, 1));
      bus.DIR_IN = 1'($urandom_range(0, 1));
      bus.FILL   = 1'($urandom_range(0, 1));
      bus.START  = 1'b1;
      pushJob(bus.WORD, 5'd7, bus.ROT, bus.DIR_IN, bus.FILL, 8, 8, 1'b1);
      @(negedge CLK);
      #1;
      bus.START = 1'b0;
      repeat (2) @(negedge CLK);
      #3;
      RESET_L = 1'b0;
      #1;
      checkResetValues("mid-job reset");
      expLoadQ.delete();
      expShiftQ.delete();
      expBitQ.delete();
      expDoneQ.delete();
      @(negedge CLK);
      #1;
      bus.WORD   = $urandom;
      bus.LEN    = 5'($urandom_range(0, 31));
      bus.ROT    = 1'($urandom_range(0, 1));
      bus.DIR_IN = 1'($urandom_range(0, 1));
      bus.FILL   = 1'($urandom_range(0, 1));
      bus.START  = 1'b1;
      pushJob(bus.WORD, bus.LEN, bus.ROT, bus.DIR_IN, bus.FILL,
              int'(bus.LEN) + 1, int'(bus.LEN) + 1, 1'b1);
      RESET_L = 1'b1;
      @(negedge CLK);
      #1;
      bus.START = 1'b0;
      check("restart BUSY", bus.BUSY, 1);
      check("restart state", stateDbg, 1);

      // All four ROT/DIR_IN combinations on a fixed word.
      for (int k = 0; k < 4; k++) begin
         combo = 2'(k);
         runJob(32'h0000_00F0, 5'd4, combo[1], combo[0], 1'($urandom_range(0, 1)), -1, 1'b0);
      end

      // Randomized jobs, some aborted, some with ABORT alongside START.
      for (int r = 0; r < 25; r++) begin
         len = $urandom_range(0, 31);
         abortAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len + 1)) : -1;
         runJob($urandom, 5'(len), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), abortAt, 1'($urandom_range(0, 1)));
      end

      waitIdle();
      repeat (3) @(negedge CLK);
      #1;
      check("leftover loads", expLoadQ.size(), 0);
      check("leftover shifts", expShiftQ.size(), 0);
      check("leftover bits", expBitQ.size(), 0);
      check("leftover dones", expDoneQ.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
